// File: rtl/mac_psum_accumulator.sv
// mac_psum_accumulator
//   Signed multiply-accumulate stage of the PE datapath. It feeds the psum truncator.
//   A window starts when `start` is seen in IDLE. The accumulator is seeded with
//   psum_in, and acc_len ifmap x filter products are summed into it. The
//   full-width psum is then offered on a valid/ready port.
//   Pipeline: stage 1 registers the product, stage 2 adds it into the accumulator.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     start               begin a window (IDLE only)
//     acc_len             products in the window, latched on start
//     psum_in             accumulator seed, latched on start
//     in_valid/in_ready   ifmap/filter pair handshake
//     ifmap, filter       signed operands
//     out_valid/out_ready result handshake
//     out_psum            accumulated psum, full width
//     busy                high whenever not IDLE
module mac_psum_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    acc_len,
  input  logic [2*DATA_WIDTH-1:0] psum_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   ifmap,
  input  logic [DATA_WIDTH-1:0]   filter,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_psum,
  output logic                    busy
);

  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic [CNT_WIDTH-1:0] remaining_r;
  logic [PW-1:0]        prod_r;
  logic                 p_vld_r;
  logic [PW-1:0]        acc_r;
  logic [PW-1:0]        out_psum_r;
  logic [PW-1:0]        ifmap_ext_s;
  logic [PW-1:0]        filter_ext_s;
  logic                 accept_s;
  logic                 xfer_s;

  // Sign-extend both operands to the product width. The low PW bits of the
  // product are then the exact signed product.
  assign ifmap_ext_s  = {{DATA_WIDTH{ifmap[DATA_WIDTH-1]}}, ifmap};
  assign filter_ext_s = {{DATA_WIDTH{filter[DATA_WIDTH-1]}}, filter};

  // All outputs are decoded purely from registered state.
  assign in_ready  = (state_r == ACCUM) && (remaining_r != '0);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign out_psum  = out_psum_r;

  assign accept_s = in_valid & in_ready;
  assign xfer_s   = out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = (acc_len == '0) ? DONE : ACCUM;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACCUM: begin
        // Leave only when every product has reached the accumulator.
        if ((remaining_r == '0) && !p_vld_r) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = ACCUM;
        end
      end
      DONE: begin
        if (xfer_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Datapath: window counter, product stage, accumulator and held result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining_r <= '0;
      prod_r      <= '0;
      p_vld_r     <= 1'b0;
      acc_r       <= '0;
      out_psum_r  <= '0;
    end else begin
      p_vld_r <= accept_s;
      if (state_r == IDLE && start) begin
        acc_r       <= psum_in;
        remaining_r <= acc_len;
      end else if (p_vld_r) begin
        acc_r <= acc_r + prod_r;  // wraps modulo 2^PW
      end
      if (accept_s) begin
        prod_r      <= ifmap_ext_s * filter_ext_s;
        remaining_r <= remaining_r - CNT_WIDTH'(1);
      end
      // Capture the result on entry to DONE. A zero-length window goes
      // straight from IDLE, so the result there is the seed itself.
      if (state_nx_s == DONE && state_r != DONE) begin
        out_psum_r <= (state_r == IDLE) ? psum_in : acc_r;
      end
    end
  end

endmodule

// File: tb/tb_mac_psum_accumulator.sv
// Directed testbench for mac_psum_accumulator. The expected values are
// worked out by hand from the window contents.
module tb_mac_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  acc_len;
  logic [31:0] psum_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ifmap;
  logic [15:0] filter;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_psum;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  mac_psum_accumulator #(.DATA_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_len(acc_len), .psum_in(psum_in),
    .in_valid(in_valid), .in_ready(in_ready), .ifmap(ifmap), .filter(filter),
    .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_window(input logic [7:0] len, input logic [31:0] seed);
    acc_len = len;
    psum_in = seed;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  // Offer a pair and hold it until it is accepted (bounded).
  task automatic send(input string tag, input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    ifmap    = a;
    filter   = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "_ready"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for the result, check it, then take it.
  task automatic collect(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_psum"}, out_psum, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; acc_len = 8'd0; psum_in = 32'd0;
    in_valid = 1'b0; ifmap = 16'd0; filter = 16'd0; out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_psum", out_psum, 32'd0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();

    // 1 Basic: 6 - 20 - 7 = -21, valid two edges after the last accept
    begin_window(8'd3, 32'd0);
    check("t1_busy", busy, 1'b1);
    send("t1_p0", 16'd2, 16'd3);
    send("t1_p1", -16'sd4, 16'd5);
    send("t1_p2", 16'd7, -16'sd1);
    check("t1_ready_drop", in_ready, 1'b0);
    check("t1_lat0", out_valid, 1'b0);
    step();
    check("t1_lat1", out_valid, 1'b0);
    step();
    check("t1_lat2", out_valid, 1'b1);
    collect("t1", 32'hFFFFFFEB);

    // 2 Seed + gaps: 100 + 100 - 12 = 188
    begin_window(8'd2, 32'd100);
    send("t2_p0", 16'd10, 16'd10);
    check("t2_ready_hold", in_ready, 1'b1);
    step(); step(); step();
    send("t2_p1", -16'sd3, 16'd4);
    check("t2_ready_drop", in_ready, 1'b0);
    collect("t2", 32'd188);

    // 3 Wrap and most-negative operands
    begin_window(8'd1, 32'h7FFFFFFF);
    send("t3a_p0", 16'd1, 16'd1);
    collect("t3a", 32'h80000000);
    begin_window(8'd1, 32'd0);
    send("t3b_p0", 16'h8000, 16'h8000);
    collect("t3b", 32'h40000000);

    // 4 Backpressure: result held, start ignored while in DONE
    begin_window(8'd1, 32'd0);
    send("t4_p0", 16'd5, 16'd6);
    step(); step();
    check("t4_valid", out_valid, 1'b1);
    acc_len = 8'd3;
    psum_in = 32'd999;
    start   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_hold_valid", out_valid, 1'b1);
      check("t4_hold_psum", out_psum, 32'd30);
    end
    start = 1'b0;
    collect("t4", 32'd30);

    // 5 Zero-length window: no pair is ever requested
    begin_window(8'd0, 32'h12345678);
    check("t5_ready0", in_ready, 1'b0);
    step();
    check("t5_ready1", in_ready, 1'b0);
    collect("t5", 32'h12345678);

    // 6 Reset mid-window, then a clean window with no residue
    begin_window(8'd4, 32'd50);
    send("t6_p0", 16'd3, 16'd3);
    rst_n = 1'b0;
    step();
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_ready", in_ready, 1'b0);
    check("t6_rst_psum", out_psum, 32'd0);
    check("t6_rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();
    begin_window(8'd2, 32'd0);
    send("t6_p1", 16'd1, 16'd2);
    send("t6_p2", 16'd3, 16'd4);
    collect("t6", 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
